uart_frame_rx: RTL and testbench

Receive-side frame parser between the UART receiver's byte interface (rdy/dout/rdy_clr) and the memory/arbiter request path. Hunts for a sync byte, then collects a fixed-length command frame (CMD, ADDR, DATA, optional CHK). Issues one validated read or write request per frame over a valid/ready handshake. Flags malformed, stalled or corrupt frames.

---
 rtl/uart_frame_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_frame_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: hunts for a sync byte on the UART rx byte port, collects
// CMD/ADDR/DATA[/CHK] and issues one read/write request per good frame.
// Define UART_FRAME_CHECKSUM_EN to add the CHK byte (CMD ^ ADDR ^ DATA).
module uart_frame_rx #(
   parameter logic [7:0] SYNC_BYTE      = 8'hAA,
   parameter int         TIMEOUT_CYCLES = 5000000
) (
   input  logic        clock_50MHz,
   input  logic        reset,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        rx_rdy_clr,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_write,
   output logic [31:0] cmd_addr,
   output logic [7:0]  cmd_wdata,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic [7:0]  frame_cnt
);

   localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   T_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      CMD_W  = 8'h57;
   localparam logic [7:0]      CMD_R  = 8'h52;

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      GET_ADDR,
      GET_DATA,
`ifdef UART_FRAME_CHECKSUM_EN
      GET_CHK,
`endif
      ISSUE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   tcnt_q;
   logic [7:0]      addr_q;
   logic [7:0]      data_q;
`ifdef UART_FRAME_CHECKSUM_EN
   logic [7:0]      cmd_byte_q;
`endif
   logic            accept;
   logic            in_get;
   logic            tmo;
   logic            err_set;
   logic [1:0]      err_val;

   // ISSUE holds the UART off so no byte is lost while waiting on cmd_ready
   assign accept    = rx_rdy && !rx_rdy_clr && (state_q != ISSUE);
   assign in_get    = (state_q != IDLE) && (state_q != ISSUE);
   assign tmo       = in_get && !accept && (tcnt_q == T_LAST);
   assign cmd_valid = (state_q == ISSUE);
   assign cmd_addr  = {24'h0, addr_q};
   assign cmd_wdata = cmd_write ? data_q : 8'h00;

   // State register
   always_ff @(posedge clock_50MHz or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and error decode; an accepted byte beats a timeout
   always_comb begin
      state_d = state_q;
      err_set = 1'b0;
      err_val = 2'b00;
      if (tmo) begin
         state_d = IDLE;
         err_set = 1'b1;
         err_val = 2'b10;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept && rx_data == SYNC_BYTE) state_d = GET_CMD;
            end
            GET_CMD: begin
               if (accept) begin
                  if (rx_data == CMD_W || rx_data == CMD_R) begin
                     state_d = GET_ADDR;
                  end else begin
                     state_d = IDLE;
                     err_set = 1'b1;
                     err_val = 2'b01;
                  end
               end
            end
            GET_ADDR: begin
               if (accept) state_d = GET_DATA;
            end
`ifdef UART_FRAME_CHECKSUM_EN
            GET_DATA: begin
               if (accept) state_d = GET_CHK;
            end
            GET_CHK: begin
               if (accept) begin
                  if (rx_data == (cmd_byte_q ^ addr_q ^ data_q)) begin
                     state_d = ISSUE;
                  end else begin
                     state_d = IDLE;
                     err_set = 1'b1;
                     err_val = 2'b11;
                  end
               end
            end
`else
            GET_DATA: begin
               if (accept) state_d = ISSUE;
            end
`endif
            ISSUE: begin
               if (cmd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Inter-byte timeout, only running while a frame is being collected
   always_ff @(posedge clock_50MHz or posedge reset) begin
      if (reset)                         tcnt_q <= '0;
      else if (accept || !in_get || tmo) tcnt_q <= '0;
      else                               tcnt_q <= tcnt_q + CW'(1);
   end

   // UART ready-clear: raise after a byte is taken, drop once rdy falls
   always_ff @(posedge clock_50MHz or posedge reset) begin
      if (reset)        rx_rdy_clr <= 1'b0;
      else if (accept)  rx_rdy_clr <= 1'b1;
      else if (!rx_rdy) rx_rdy_clr <= 1'b0;
   end

   // Frame field capture
   always_ff @(posedge clock_50MHz or posedge reset) begin
      if (reset) begin
         cmd_write  <= 1'b0;
         addr_q     <= 8'h00;
         data_q     <= 8'h00;
`ifdef UART_FRAME_CHECKSUM_EN
         cmd_byte_q <= 8'h00;
`endif
      end else if (accept) begin
         if (state_q == GET_CMD) begin
            cmd_write  <= (rx_data == CMD_W);
`ifdef UART_FRAME_CHECKSUM_EN
            cmd_byte_q <= rx_data;
`endif
         end
         if (state_q == GET_ADDR) addr_q <= rx_data;
         if (state_q == GET_DATA) data_q <= rx_data;
      end
   end

   // Error pulse, sticky error code and issued-request counter
   always_ff @(posedge clock_50MHz or posedge reset) begin
      if (reset) begin
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         frame_cnt <= 8'h00;
      end else begin
         frame_err <= err_set;
         if (err_set) err_code <= err_val;
         if (state_q == ISSUE && cmd_ready) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed frames against uart_frame_rx with a short
// timeout; expectations follow UART_FRAME_CHECKSUM_EN when it is defined.
module tb_uart_frame_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        rx_rdy_clr;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [7:0]  frame_cnt;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int hs_cnt = 0;
   int xfer_cnt = 0;
   int valid_cyc = 0;
   int err_cnt = 0;
   int err_cyc = 0;
   int acc_cyc = 0;
   logic        clr_prev = 1'b0;
   logic [1:0]  last_code = 2'b00;
   logic        last_write = 1'b0;
   logic [31:0] last_addr = '0;
   logic [7:0]  last_wdata = '0;

   uart_frame_rx #(
      .SYNC_BYTE      (8'hAA),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clock_50MHz (clk),
      .reset       (reset),
      .rx_rdy      (rx_rdy),
      .rx_data     (rx_data),
      .rx_rdy_clr  (rx_rdy_clr),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .frame_err   (frame_err),
      .err_code    (err_code),
      .frame_cnt   (frame_cnt)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc++;

   // Observe handshakes, transfers and error pulses mid-cycle
   always @(negedge clk) begin
      if (rx_rdy && !rx_rdy_clr && !cmd_valid && !reset) acc_cyc = cyc;
      if (rx_rdy_clr && !clr_prev) hs_cnt++;
      clr_prev = rx_rdy_clr;
      if (cmd_valid) valid_cyc++;
      if (cmd_valid && cmd_ready) begin
         xfer_cnt++;
         last_write = cmd_write;
         last_addr  = cmd_addr;
         last_wdata = cmd_wdata;
      end
      if (frame_err) begin
         err_cnt++;
         err_cyc   = cyc;
         last_code = err_code;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic finish_byte();
      int n;
      n = 0;
      while (!rx_rdy_clr && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("clr_rise", 32'(rx_rdy_clr), 1);
      rx_rdy = 1'b0;
      n = 0;
      while (rx_rdy_clr && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("clr_fall", 32'(rx_rdy_clr), 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_rdy  = 1'b1;
      finish_byte();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int hs0, x0, v0, e0, lat, bad, exp_cnt;

   initial begin
      reset     = 1'b1;
      rx_rdy    = 1'b0;
      rx_data   = 8'h00;
      cmd_ready = 1'b0;
      exp_cnt   = 0;
      idle(3);
      check("rst_valid", 32'(cmd_valid), 0);
      check("rst_clr",   32'(rx_rdy_clr), 0);
      check("rst_err",   32'(frame_err), 0);
      check("rst_code",  32'(err_code), 0);
      check("rst_cnt",   32'(frame_cnt), 0);
      check("rst_addr",  cmd_addr, 0);
      reset = 1'b0;
      idle(2);

      // Write frame with ready already high
      cmd_ready = 1'b1;
      hs0 = hs_cnt; x0 = xfer_cnt; v0 = valid_cyc; e0 = err_cnt;
      send_byte(8'hAA); send_byte(8'h57);
      send_byte(8'h32); send_byte(8'h5C);
`ifdef UART_FRAME_CHECKSUM_EN
      send_byte(8'h39);
      check("w_hs", hs_cnt - hs0, 5);
`else
      check("w_hs", hs_cnt - hs0, 4);
`endif
      idle(4);
      exp_cnt++;
      check("w_xfer",  xfer_cnt - x0, 1);
      check("w_vcyc",  valid_cyc - v0, 1);
      check("w_write", 32'(last_write), 1);
      check("w_addr",  last_addr, 50);
      check("w_wdata", 32'(last_wdata), 32'h5C);
      check("w_cnt",   32'(frame_cnt), exp_cnt);
      check("w_noerr", err_cnt - e0, 0);

      // Leading garbage, then a read frame
      x0 = xfer_cnt; e0 = err_cnt;
      send_byte(8'h00); send_byte(8'h13);
      send_byte(8'hAA); send_byte(8'h52);
      send_byte(8'h32); send_byte(8'h00);
`ifdef UART_FRAME_CHECKSUM_EN
      send_byte(8'h60);
`endif
      idle(4);
      exp_cnt++;
      check("r_xfer",  xfer_cnt - x0, 1);
      check("r_write", 32'(last_write), 0);
      check("r_addr",  last_addr, 50);
      check("r_wdata", 32'(last_wdata), 0);
      check("r_cnt",   32'(frame_cnt), exp_cnt);
      check("r_noerr", err_cnt - e0, 0);

      // Bad command byte, then a good write frame
      x0 = xfer_cnt; e0 = err_cnt;
      send_byte(8'hAA); send_byte(8'h41);
      idle(3);
      check("bc_err",  err_cnt - e0, 1);
      check("bc_code", 32'(last_code), 1);
      check("bc_hold", 32'(err_code), 1);
      check("bc_noxf", xfer_cnt - x0, 0);
      send_byte(8'hAA); send_byte(8'h57);
      send_byte(8'h10); send_byte(8'hFF);
`ifdef UART_FRAME_CHECKSUM_EN
      send_byte(8'hB8);
`endif
      idle(4);
      exp_cnt++;
      check("bc2_xfer",  xfer_cnt - x0, 1);
      check("bc2_addr",  last_addr, 16);
      check("bc2_wdata", 32'(last_wdata), 32'hFF);
      check("bc2_cnt",   32'(frame_cnt), exp_cnt);
      check("bc2_err",   err_cnt - e0, 1);

      // Timeout after CMD, then silence in IDLE
      x0 = xfer_cnt; e0 = err_cnt;
      send_byte(8'hAA); send_byte(8'h57);
      for (int i = 0; i < 300 && err_cnt == e0; i++) @(posedge clk);
      #1;
      check("to_err", err_cnt - e0, 1);
      lat = err_cyc - acc_cyc;
      check("to_lat",  32'(lat >= 100 && lat <= 101), 1);
      check("to_code", 32'(last_code), 2);
      idle(150);
      check("to_idle", err_cnt - e0, 1);
      check("to_noxf", xfer_cnt - x0, 0);

`ifdef UART_FRAME_CHECKSUM_EN
      // Corrupt checksum
      x0 = xfer_cnt; e0 = err_cnt;
      send_byte(8'hAA); send_byte(8'h57);
      send_byte(8'h32); send_byte(8'h5C);
      send_byte(8'h00);
      idle(4);
      check("ck_err",  err_cnt - e0, 1);
      check("ck_code", 32'(last_code), 3);
      check("ck_noxf", xfer_cnt - x0, 0);
      check("ck_cnt",  32'(frame_cnt), exp_cnt);
`else
      // Four-byte frame; trailing byte is dropped in IDLE
      x0 = xfer_cnt; e0 = err_cnt; hs0 = hs_cnt;
      send_byte(8'hAA); send_byte(8'h57);
      send_byte(8'h32); send_byte(8'h5C);
      send_byte(8'h00);
      idle(4);
      exp_cnt++;
      check("nc_xfer",  xfer_cnt - x0, 1);
      check("nc_addr",  last_addr, 50);
      check("nc_wdata", 32'(last_wdata), 32'h5C);
      check("nc_hs",    hs_cnt - hs0, 5);
      check("nc_noerr", err_cnt - e0, 0);
      check("nc_cnt",   32'(frame_cnt), exp_cnt);
`endif

      // Backpressure: ready low 20 cycles with a byte pending
      cmd_ready = 1'b0;
      x0 = xfer_cnt;
      send_byte(8'hAA); send_byte(8'h57);
      send_byte(8'h21); send_byte(8'h3C);
`ifdef UART_FRAME_CHECKSUM_EN
      send_byte(8'h4A);
`endif
      @(posedge clk); #1;
      rx_data = 8'h99;
      rx_rdy  = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (cmd_valid !== 1'b1 || rx_rdy_clr !== 1'b0 ||
             cmd_write !== 1'b1 || cmd_addr !== 32'h21 ||
             cmd_wdata !== 8'h3C)
            bad++;
      end
      check("bp_stable", bad, 0);
      check("bp_cnt",    32'(frame_cnt), exp_cnt);
      @(posedge clk); #1;
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      exp_cnt++;
      check("bp_valid", 32'(cmd_valid), 0);
      check("bp_xfer",  xfer_cnt - x0, 1);
      check("bp_cnt2",  32'(frame_cnt), exp_cnt);
      finish_byte();

      // Reset while stalled in ISSUE
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(2);
      x0 = xfer_cnt;
      send_byte(8'hAA); send_byte(8'h52);
      send_byte(8'h05); send_byte(8'h00);
`ifdef UART_FRAME_CHECKSUM_EN
      send_byte(8'h57);
`endif
      @(posedge clk); #1;
      rx_data = 8'h11;
      rx_rdy  = 1'b1;
      idle(5);
      check("rs_pre", 32'(cmd_valid), 1);
      reset = 1'b1;
      #1;
      check("rs_valid", 32'(cmd_valid), 0);
      check("rs_cnt",   32'(frame_cnt), 0);
      rx_rdy = 1'b0;
      idle(2);
      reset = 1'b0;
      cmd_ready = 1'b1;
      idle(10);
      check("rs_noxf", xfer_cnt - x0, 0);
      check("rs_cnt2", 32'(frame_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
